// File: rtl/counter_seq_pkg.sv
// ----------------------------------------------------------------------------
// counter_seq_pkg
//
// Shared definitions for the counter_sequencer block.
//   - state_e       : sequencer state encoding (IDLE = 0, RUN = 1)
//   - DefaultWidth  : default counter / limit width
//   - DefaultPreW   : default prescale field width
//   - DefaultPerW   : default completed-period tally width
// ----------------------------------------------------------------------------
package counter_seq_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultPreW  = 4;
    localparam int unsigned DefaultPerW  = 8;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
//
// Cycle prescaler for the counter_sequencer. Produces one tick every
// pre_q+1 enabled cycles. The internal counter pre_cnt runs 0..pre_q.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   clear   in   restart the prescaler from 0 (accepted start)
//   enable  in   prescaler runs only while high (sequencer in RUN)
//   pre_q   in   latched prescale value
//   tick    out  high on the cycle the prescaler reaches pre_q
// ----------------------------------------------------------------------------
module tick_gen
    import counter_seq_pkg::*;
#(
    parameter int unsigned PRE_W = DefaultPreW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [PRE_W-1:0] pre_q,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    assign tick = enable && (pre_cnt == pre_q);

    // clear wins over tick so a restart always begins a full prescale interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (clear) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else if (enable) begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// ----------------------------------------------------------------------------
// counter_sequencer
//
// Interval timer controller: sequences an up-counter from 0 to a latched
// terminal value, advancing once per prescaled tick. One-shot mode stops at
// the terminal value; periodic mode reloads to 0 and keeps running.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   start     in   strobe: latch config and (re)start counting from 0
//   stop      in   strobe: halt counting, hold count (beats start)
//   periodic  in   mode sampled on start: 1 = auto-reload, 0 = one-shot
//   limit     in   terminal count sampled on start
//   prescale  in   tick divider sampled on start (tick every prescale+1)
//   count     out  current counter value
//   busy      out  high while running
//   done      out  one-cycle pulse after the terminal tick
//   periods   out  done pulses since the last start (wraps)
// ----------------------------------------------------------------------------
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned PRE_W = DefaultPreW,
    parameter int unsigned PER_W = DefaultPerW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [PER_W-1:0] periods
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] count_q, count_d;
    logic [PER_W-1:0] periods_q, periods_d;
    logic             done_q, done_d;

    // Configuration captured on an accepted start only.
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             per_q, per_d;

    logic clear;
    logic tick;
    logic terminal;

    tick_gen #(
        .PRE_W (PRE_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (state_q == StRun),
        .pre_q  (pre_q),
        .tick   (tick)
    );

    assign terminal = (count_q == limit_q);

    // Priority: stop > start > tick. A start or stop landing on the terminal
    // tick suppresses that tick's done pulse and period increment.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        periods_d = periods_q;
        done_d    = 1'b0;
        limit_d   = limit_q;
        pre_d     = pre_q;
        per_d     = per_q;
        clear     = 1'b0;

        if (stop) begin
            state_d = StIdle;
        end else if (start) begin
            state_d   = StRun;
            count_d   = '0;
            periods_d = '0;
            limit_d   = limit;
            pre_d     = prescale;
            per_d     = periodic;
            clear     = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Hold everything until the next start.
                end
                StRun: begin
                    if (tick) begin
                        if (terminal) begin
                            done_d    = 1'b1;
                            periods_d = periods_q + 1'b1;
                            if (per_q) begin
                                count_d = '0;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            periods_q <= '0;
            done_q    <= 1'b0;
            limit_q   <= '0;
            pre_q     <= '0;
            per_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            periods_q <= periods_d;
            done_q    <= done_d;
            limit_q   <= limit_d;
            pre_q     <= pre_d;
            per_q     <= per_d;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q == StRun);
    assign done    = done_q;
    assign periods = periods_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// ----------------------------------------------------------------------------
// tb_counter_sequencer
//
// Self-checking bench for counter_sequencer. The reference model tracks the
// number of edges elapsed since the last accepted start and derives count,
// done and periods from it in closed form.
// ----------------------------------------------------------------------------
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [7:0] limit;
    logic [3:0] prescale;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [7:0] periods;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit m_active;
    int m_t;          // edges since the accepted start
    int m_l;
    int m_p;
    bit m_per;
    int m_count;      // held values while not running
    int m_periods;
    bit m_done;

    counter_sequencer #(
        .WIDTH (8),
        .PRE_W (4),
        .PER_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .limit    (limit),
        .prescale (prescale),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .periods  (periods)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int period_len();
        return (m_l + 1) * (m_p + 1);
    endfunction

    function automatic int exp_count();
        if (m_active) return (m_t / (m_p + 1)) % (m_l + 1);
        return m_count;
    endfunction

    function automatic int exp_periods();
        if (m_active) return (m_t / period_len()) % 256;
        return m_periods;
    endfunction

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        if (rst) begin
            m_active  = 1'b0;
            m_t       = 0;
            m_l       = 0;
            m_p       = 0;
            m_per     = 1'b0;
            m_count   = 0;
            m_periods = 0;
            m_done    = 1'b0;
        end else if (stop) begin
            if (m_active) begin
                m_count   = exp_count();
                m_periods = exp_periods();
            end
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            m_t      = 0;
            m_l      = int'(limit);
            m_p      = int'(prescale);
            m_per    = periodic;
            m_done   = 1'b0;
        end else if (m_active) begin
            m_t++;
            if (!m_per && m_t == period_len()) begin
                m_active  = 1'b0;
                m_count   = m_l;
                m_periods = 1;
                m_done    = 1'b1;
            end else begin
                m_done = (m_t % period_len() == 0);
            end
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("count", count, exp_count());
        check_eq("busy", busy, m_active);
        check_eq("done", done, m_done);
        check_eq("periods", periods, exp_periods());
    endtask

    task automatic do_start(input int l, input int p, input bit per);
        start    = 1'b1;
        limit    = 8'(l);
        prescale = 4'(p);
        periodic = per;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        limit    = '0;
        prescale = '0;
        step();
        check_eq("reset_count", count, 0);
        check_eq("reset_busy", busy, 0);
        rst = 1'b0;
        step();

        // One-shot, limit 3, no prescale.
        do_start(3, 0, 1'b0);
        check_eq("t1_start_count", count, 0);
        repeat (3) step();
        check_eq("t1_count3", count, 3);
        check_eq("t1_busy_before", busy, 1);
        step();
        check_eq("t1_done", done, 1);
        check_eq("t1_busy_fall", busy, 0);
        repeat (2) step();
        check_eq("t1_hold", count, 3);
        check_eq("t1_periods", periods, 1);

        // Periodic, limit 2, prescale 2, 27 cycles.
        do_start(2, 2, 1'b1);
        repeat (27) step();
        check_eq("t2_periods", periods, 3);

        // Stop on the terminal tick of a one-shot.
        do_start(5, 0, 1'b0);
        repeat (5) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("t3_no_done", done, 0);
        check_eq("t3_periods", periods, 0);
        check_eq("t3_count", count, 5);
        check_eq("t3_busy", busy, 0);
        repeat (3) step();

        // start+stop together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        limit = 8'd9;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check_eq("t4_idle_busy", busy, 0);
        check_eq("t4_idle_count", count, 5);

        // Restart mid-run at count 4 with a new limit.
        do_start(9, 0, 1'b0);
        repeat (4) step();
        check_eq("t4_count4", count, 4);
        do_start(2, 0, 1'b0);
        check_eq("t4_restart", count, 0);
        repeat (4) step();
        check_eq("t4_new_limit", count, 2);

        // limit 0, prescale 0, periodic: done every cycle, periods wraps.
        do_start(0, 0, 1'b1);
        repeat (300) step();
        check_eq("t5_periods_wrap", periods, 300 % 256);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Reset mid-run at count 7.
        do_start(10, 0, 1'b1);
        repeat (7) step();
        check_eq("t6_count7", count, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_rst_count", count, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_periods", periods, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 399) == 0);
            start    = ($urandom_range(0, 29) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            periodic = 1'($urandom_range(0, 1));
            limit    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 12));
            prescale = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Programmable controller that sequences an 8-bit up-counter as an interval timer. It offers start/stop control, a latched terminal value, a cycle prescaler, and one-shot or periodic modes. It sits between software-facing control strobes and the counter datapath. It reports live count, busy status, a terminal-count pulse and a completed-period tally.

## Interface
Parameters:
- `WIDTH`, 8: counter and limit width.
- `PRE_W`, 4: prescale field width.
- `PER_W`, 8: completed-period tally width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle strobe; latches config and (re)starts counting from 0.
- `stop`  in  1  one-cycle strobe; halts counting, holds count.
- `periodic`  in  1  mode, sampled on accepted `start`; 1 = auto-reload, 0 = one-shot.
- `limit`  in  WIDTH  terminal count, sampled on accepted `start`.
- `prescale`  in  PRE_W  tick divider, sampled on accepted `start`; one tick every `prescale+1` cycles.
- `count`  out  WIDTH  current counter value.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at terminal tick.
- `periods`  out  PER_W  number of `done` pulses since last `start`.

## Operation
- States: IDLE, RUN.
- Config registers `limit_q`, `pre_q` and `per_q` load only on an accepted `start`. Port changes at other times have no effect.
- The prescaler `pre_cnt` counts 0..`pre_q`.
  - `tick` = RUN && `pre_cnt == pre_q`.
  - On tick, `pre_cnt` <= 0; otherwise it increments.
- IDLE:
  - `start` && !`stop` -> RUN.
  - On that transition: `count` <= 0, `pre_cnt` <= 0, `periods` <= 0, config latched.
  - `count` holds its last value in IDLE.
- RUN, tick with `count != limit_q`: `count` <= `count`+1.
- RUN, tick with `count == limit_q` (terminal):
  - `done` <= 1.
  - `periods` <= `periods`+1, wrapping modulo 2^PER_W.
  - Periodic: `count` <= 0 and stay in RUN.
  - One-shot: `count` holds `limit_q` and go to IDLE.
- RUN, `stop`: go to IDLE next edge; `count` holds; no `done`.
- Priorities:
  - `stop` beats `start` in any state.
  - `stop` beats a terminal tick: no `done`, `periods` unchanged.
- `start` in RUN (without `stop`) restarts: same actions as from IDLE. A coincident terminal tick is discarded (no `done`).
- `limit == 0`: first tick is terminal.
- Terminal period = (`limit_q`+1)·(`pre_q`+1) cycles.
- Arithmetic is unsigned. `count` never exceeds `limit_q` and never wraps past it.

## Timing
- Reset (`rst` high at an edge): state=IDLE; `count`=0, `busy`=0, `done`=0, `periods`=0; `pre_cnt`=0; config regs=0. Reset mid-RUN aborts immediately with no `done`.
- All outputs are registered; no combinational input-to-output paths.
- `start` sampled at edge E0: `busy`=1 and `count`=0 from E0.
- With `pre_q`=0, `count`=k after edge E0+k.
- Terminal tick at edge E0+`limit_q`+1 (prescale 0): `done`=1 for exactly the cycle after that edge.
  - One-shot: `busy`=0 in that same cycle.
- `done` is never high for two consecutive cycles unless `limit_q`=0 and `pre_q`=0 in periodic mode. In that case `done` stays high every cycle.
- `stop` at edge E: `busy`=0 after E.

## Structure
- Package `counter_seq_pkg`: state encoding (IDLE=0, RUN=1) and default widths `WIDTH`, `PRE_W`, `PER_W`.
- Sub-module `tick_gen`:
  - Ports: `clk`, `rst`, `clear`, `enable`, `pre_q`, `tick`.
  - Contains `pre_cnt`.
  - `clear` is driven on accepted `start`.
- The top holds the FSM, config regs, `count`, `periods` and `done`.

## Test plan
- Reset, then `start` with `limit`=3, `prescale`=0, `periodic`=0 -> `count` 0,1,2,3 on successive cycles; `done`=1 one cycle after count reaches 3; `busy` falls with it; `count` holds 3; `periods`=1.
- `limit`=2, `prescale`=2, `periodic`=1, run 27 cycles -> `count` steps every 3 cycles; `done` every 9 cycles; `periods`=3.
- `stop` asserted on the terminal-tick cycle (one-shot, `limit`=5) -> no `done`; `periods`=0; `count` holds 5; `busy`=0.
- `start` and `stop` together in IDLE -> stays IDLE; `count`/`periods` unchanged. `start` mid-RUN at `count`=4 -> `count`=0 next cycle, new `limit` used.
- `limit`=0, `prescale`=0, periodic, 300 cycles -> `done` constantly high; `periods` wraps 255->0.
- `rst` asserted mid-RUN at `count`=7 -> next cycle all outputs 0; state IDLE.
